// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: memory-mapped front end for the RV32I UART core.
// It buffers TX bytes in a FIFO, drives the core's start-of-transmit handshake
// one byte at a time, and captures each received byte on the RXNE rising edge
// into an RX FIFO.
// Ports:
//   i_clk, i_rst          clock, synchronous active-low reset
//   i_addr/i_we/i_re      bus access: 0 CTRL, 1 STATUS, 2 TXDATA, 3 RXDATA
//   i_wdata, o_rdata      bus write data, registered read data
//   o_irq                 level interrupt (RX not empty / TX drained)
//   o_en/o_br/o_clk_dec   core configuration from CTRL
//   o_str_tx, o_data_tx   transmit request and byte to the core
//   i_busy_tx             core TX busy
//   i_rxne, i_data_rx     core byte-received flag and byte
module uart_mmio_ctrl #(
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_addr,
  input  logic        i_we,
  input  logic        i_re,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq,
  output logic        o_en,
  output logic [3:0]  o_br,
  output logic [7:0]  o_clk_dec,
  output logic        o_str_tx,
  output logic [7:0]  o_data_tx,
  input  logic        i_busy_tx,
  input  logic        i_rxne,
  input  logic [7:0]  i_data_rx
);

  localparam int unsigned TAW = $clog2(TX_DEPTH);
  localparam int unsigned TCW = TAW + 1;
  localparam int unsigned RAW = $clog2(RX_DEPTH);
  localparam int unsigned RCW = RAW + 1;
  localparam logic [TCW-1:0] TxFullCnt = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0] RxFullCnt = RCW'(RX_DEPTH);
  // Bit 1 of CTRL is unimplemented and reads 0.
  localparam logic [15:0] CtrlMask = 16'hFFFD;

  typedef enum logic [1:0] {TIdle, TReq, TWait, TRel} tx_state_e;

  tx_state_e      state_q, state_d;
  logic           str_q, str_d;
  logic [7:0]     data_tx_q, data_tx_d;
  logic [31:0]    rdata_q, rdata_d, rd_mux;
  logic [15:0]    ctrl_q, ctrl_d;
  logic           rxovr_q, rxovr_d, txdrop_q, txdrop_d;
  logic           rxne_q;

  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [TAW-1:0] tx_wp_q, tx_rp_q;
  logic [TCW-1:0] tx_cnt_q;
  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [RAW-1:0] rx_wp_q, rx_rp_q;
  logic [RCW-1:0] rx_cnt_q;

  logic wr_ctrl, wr_stat, wr_tx, rd_rx, flush;
  logic tx_full, tx_empty, tx_push, tx_pop, tx_drop;
  logic rx_full, rx_empty, rx_edge, rx_push, rx_pop, rx_drop;
  logic tbusy;
  logic [31:0] status;
  logic unused_wdata;

  assign unused_wdata = ^i_wdata[31:16];

  assign wr_ctrl = i_we && (i_addr == 2'd0);
  assign wr_stat = i_we && (i_addr == 2'd1);
  assign wr_tx   = i_we && (i_addr == 2'd2);
  assign rd_rx   = i_re && (i_addr == 2'd3);
  assign flush   = wr_ctrl && !i_wdata[0];

  // Full/empty use start-of-cycle counts, so a same-cycle pop never rescues a push.
  assign tx_full  = (tx_cnt_q == TxFullCnt);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_push  = wr_tx && !tx_full;
  assign tx_drop  = wr_tx && tx_full;

  assign rx_full  = (rx_cnt_q == RxFullCnt);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_edge  = i_rxne && !rxne_q;
  assign rx_push  = rx_edge && !rx_full;
  assign rx_drop  = rx_edge && rx_full;
  assign rx_pop   = rd_rx && !rx_empty;

  assign tbusy  = (state_q != TIdle) || i_busy_tx;
  assign status = {16'h0, 4'(rx_cnt_q), 4'(tx_cnt_q), 2'b00, txdrop_q, rxovr_q,
                   tx_empty, tx_full, !rx_empty, tbusy};

  // TX handshake FSM
  always_comb begin
    state_d   = state_q;
    str_d     = str_q;
    data_tx_d = data_tx_q;
    tx_pop    = 1'b0;
    case (state_q)
      TIdle: begin
        if (ctrl_q[0] && !tx_empty) begin
          tx_pop    = 1'b1;
          data_tx_d = tx_mem_q[tx_rp_q];
          str_d     = 1'b1;
          state_d   = TReq;
        end
      end
      TReq:  if (i_busy_tx) state_d = TWait;
      TWait: begin
        if (!i_busy_tx) begin
          str_d   = 1'b0;
          state_d = TRel;
        end
      end
      TRel:    state_d = TIdle;
      default: state_d = TIdle;
    endcase
    if (flush) begin
      state_d = TIdle;
      str_d   = 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (i_addr)
      2'd0: rd_mux = {16'h0, ctrl_q};
      2'd1: rd_mux = status;
      2'd2: rd_mux = '0;
      2'd3: if (!rx_empty) rd_mux = {24'h0, rx_mem_q[rx_rp_q]};
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    ctrl_d   = wr_ctrl ? (i_wdata[15:0] & CtrlMask) : ctrl_q;
    rdata_d  = i_re ? rd_mux : rdata_q;
    // A new drop event wins over a same-cycle write-1-to-clear.
    rxovr_d  = rx_drop ? 1'b1 : ((wr_stat && i_wdata[4]) ? 1'b0 : rxovr_q);
    txdrop_d = tx_drop ? 1'b1 : ((wr_stat && i_wdata[5]) ? 1'b0 : txdrop_q);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= TIdle;
      str_q     <= 1'b0;
      data_tx_q <= '0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      rxovr_q   <= 1'b0;
      txdrop_q  <= 1'b0;
      rxne_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      str_q     <= str_d;
      data_tx_q <= data_tx_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      rxovr_q   <= rxovr_d;
      txdrop_q  <= txdrop_d;
      rxne_q    <= flush ? 1'b0 : i_rxne;
    end
  end

  // FIFO pointers and counts; flush has priority over any same-cycle push/pop.
  always_ff @(posedge i_clk) begin
    if (!i_rst || flush) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      tx_cnt_q <= tx_cnt_q + TCW'(tx_push) - TCW'(tx_pop);
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      rx_cnt_q <= rx_cnt_q + RCW'(rx_push) - RCW'(rx_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= i_wdata[7:0];
    if (rx_push) rx_mem_q[rx_wp_q] <= i_data_rx;
  end

  assign o_rdata   = rdata_q;
  assign o_irq     = (ctrl_q[2] && !rx_empty) || (ctrl_q[3] && tx_empty && (state_q == TIdle));
  assign o_en      = ctrl_q[0];
  assign o_br      = ctrl_q[7:4];
  assign o_clk_dec = ctrl_q[15:8];
  assign o_str_tx  = str_q;
  assign o_data_tx = data_tx_q;

endmodule
